// File: rtl/ser_bit_source.sv
// Word-to-bit serializer: a DEPTH-word FIFO feeds a 32-bit shift register that
// presents one bit (MSB first) to the CPU serial input per rd_bit strobe.
module ser_bit_source #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     rd_bit,
  input  logic                     clr,
  output logic                     ser,
  output logic                     empty,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      mem [DEPTH];
  logic [PW-1:0]    rptr, wptr;
  logic [LW-1:0]    lvl;
  logic [31:0]      shreg;
  logic [4:0]       bcnt;
  logic             uflow;
  logic             push, load, shift, finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (lvl != '0) begin
            load      = 1'b1;
            state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          if (rd_bit) begin
            if (bcnt != 5'd31) begin
              shift = 1'b1;
            end else if (lvl != '0) begin
              load = 1'b1;
            end else begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_ready = (lvl < FULL);
    empty    = (state == IDLE) && (lvl == '0);
    push     = wr_valid && wr_ready && !clr;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // shreg is zeroed whenever the block returns to IDLE, so ser can be taken
  // straight from shreg[31] and still read 0 while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      lvl   <= '0;
      shreg <= '0;
      bcnt  <= '0;
      uflow <= 1'b0;
    end else if (clr) begin
      rptr  <= '0;
      wptr  <= '0;
      lvl   <= '0;
      shreg <= '0;
      bcnt  <= '0;
      uflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (load) rptr <= rptr + PW'(1);
      if (push && !load)      lvl <= lvl + LW'(1);
      else if (!push && load) lvl <= lvl - LW'(1);
      if (load) begin
        shreg <= mem[rptr];
        bcnt  <= '0;
      end else if (shift) begin
        shreg <= {shreg[30:0], 1'b0};
        bcnt  <= bcnt + 5'd1;
      end else if (finish) begin
        shreg <= '0;
        bcnt  <= '0;
      end
      if (rd_bit && (state == IDLE)) uflow <= 1'b1;
    end
  end

  assign ser       = shreg[31];
  assign underflow = uflow;
  assign level     = lvl;

endmodule

// File: tb/tb_ser_bit_source.sv
// Directed bench for ser_bit_source: expected bits are queued per accepted word
// and popped as each rd_bit strobe consumes the presented bit.
module tb_ser_bit_source;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        rd_bit;
  logic        clr;
  logic        ser;
  logic        empty;
  logic        underflow;
  logic [2:0]  level;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        sb[$];

  ser_bit_source #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_bit    (rd_bit),
    .clr       (clr),
    .ser       (ser),
    .empty     (empty),
    .underflow (underflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) sb.push_back(w[i]);
  endtask

  task automatic step(input logic wv, input logic [31:0] wd, input logic rb, input logic cl);
    wr_valid = wv;
    wr_data  = wd;
    rd_bit   = rb;
    clr      = cl;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_bit   = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w, input logic exp_ready, input string tag);
    check(tag, 32'(wr_ready), 32'(exp_ready));
    step(1'b1, w, 1'b0, 1'b0);
    if (exp_ready) push_word(w);
  endtask

  task automatic consume(input string tag);
    logic exp_bit;
    if (sb.size() == 0) begin
      check({tag, "_sb_underrun"}, 32'(sb.size()), 32'd1);
    end else begin
      exp_bit = sb.pop_front();
      check(tag, 32'(ser), 32'(exp_bit));
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic drain(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) consume(tag);
  endtask

  initial begin
    logic [31:0] w;
    rst      = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_bit   = 1'b0;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ser",       32'(ser),       32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_wr_ready",  32'(wr_ready),  32'd1);
    check("rst_level",     32'(level),     32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // single word with 2-cycle write-to-bit latency
    write_word(32'h8000_0001, 1'b1, "single_wr_ready");
    check("single_lat_ser",   32'(ser),   32'd0);
    check("single_lat_level", 32'(level), 32'd1);
    check("single_lat_empty", 32'(empty), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("single_load_level", 32'(level), 32'd0);
    drain(32, "single_bit");
    check("single_end_empty", 32'(empty),     32'd1);
    check("single_end_uflow", 32'(underflow), 32'd0);
    check("single_end_ser",   32'(ser),       32'd0);

    // gapless hand-over between two words
    write_word(32'hFFFF_0000, 1'b1, "gap_wr0");
    write_word(32'h0000_FFFF, 1'b1, "gap_wr1");
    drain(32, "gap_bit_a");
    check("gap_mid_level", 32'(level), 32'd0);
    check("gap_mid_empty", 32'(empty), 32'd0);
    drain(32, "gap_bit_b");
    check("gap_end_empty", 32'(empty), 32'd1);

    // full FIFO: 1 active + 4 queued accepted, rest dropped
    for (int k = 0; k < 10; k++) begin
      w = 32'h9E37_79B9 * (k + 1);
      write_word(w, (k < 5), "full_wr_ready");
    end
    check("full_level",    32'(level),    32'd4);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_empty",    32'(empty),    32'd0);
    drain(160, "full_bit");
    check("full_end_empty", 32'(empty), 32'd1);
    check("full_end_level", 32'(level), 32'd0);
    check("full_sb_left",   32'(sb.size()), 32'd0);

    // underflow then clr
    step(1'b0, '0, 1'b1, 1'b0);
    check("uf_flag",  32'(underflow), 32'd1);
    check("uf_ser",   32'(ser),       32'd0);
    check("uf_empty", 32'(empty),     32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("uf_clr_flag",  32'(underflow), 32'd0);
    check("uf_clr_level", 32'(level),     32'd0);
    check("uf_clr_empty", 32'(empty),     32'd1);

    // clr mid-word wins over same-cycle write and rd_bit
    write_word(32'hF0F0_F0F0, 1'b1, "clr_wr0");
    step(1'b0, '0, 1'b0, 1'b0);
    write_word(32'h1357_9BDF, 1'b1, "clr_wr1");
    drain(5, "clr_pre_bit");
    step(1'b1, 32'hAAAA_5555, 1'b1, 1'b1);
    sb.delete();
    check("clr_level",    32'(level),     32'd0);
    check("clr_empty",    32'(empty),     32'd1);
    check("clr_ser",      32'(ser),       32'd0);
    check("clr_uflow",    32'(underflow), 32'd0);
    check("clr_wr_ready", 32'(wr_ready),  32'd1);
    write_word(32'hB00C_0A5E, 1'b1, "clr_post_wr");
    step(1'b0, '0, 1'b0, 1'b0);
    drain(32, "clr_post_bit");
    check("clr_post_empty", 32'(empty), 32'd1);

    // pop at level 4 with a refused same-cycle write
    for (int k = 0; k < 5; k++) begin
      w = 32'hC0DE_0000 + 32'h0011_0F03 * k;
      write_word(w, 1'b1, "sim_wr_ready");
    end
    check("sim_level_full", 32'(level), 32'd4);
    drain(31, "sim_bit");
    check("sim_wr_ready_low", 32'(wr_ready), 32'd0);
    check("sim_bit32", 32'(ser), 32'(sb.pop_front()));
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("sim_level_after",    32'(level),    32'd3);
    check("sim_wr_ready_after", 32'(wr_ready), 32'd1);
    drain(128, "sim_drain_bit");
    check("sim_end_empty", 32'(empty), 32'd1);
    check("sim_sb_left",   32'(sb.size()), 32'd0);

    // asynchronous reset mid-word (bcnt=12, level=2)
    write_word(32'hFFF8_0000, 1'b1, "ar_wr0");
    write_word(32'hCAFE_F00D, 1'b1, "ar_wr1");
    write_word(32'h0BAD_CAFE, 1'b1, "ar_wr2");
    drain(12, "ar_bit");
    check("ar_pre_level", 32'(level), 32'd2);
    check("ar_pre_ser",   32'(ser),   32'd1);
    #3 rst = 1'b0;
    #1;
    check("ar_ser",      32'(ser),      32'd0);
    check("ar_level",    32'(level),    32'd0);
    check("ar_empty",    32'(empty),    32'd1);
    check("ar_wr_ready", 32'(wr_ready), 32'd1);
    sb.delete();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    write_word(32'h5A5A_C3C3, 1'b1, "ar_post_wr");
    step(1'b0, '0, 1'b0, 1'b0);
    drain(32, "ar_post_bit");
    check("ar_post_empty", 32'(empty),     32'd1);
    check("ar_post_uflow", 32'(underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ser_bit_source.md
SER_BIT_SOURCE -- requirements
Module: ser_bit_source

Interface
REQ-001 Parameter: DEPTH, default 4, word capacity of the input FIFO; power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 wr_data  input  32  word to serialize, MSB sent first.
REQ-005 wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 wr_ready  output  1  FIFO can accept a word this cycle.
REQ-007 rd_bit  input  1  one-cycle consume strobe from the CPU rdBit decode; one bit per strobe.
REQ-008 clr  input  1  synchronous flush strobe, driven from a wrReg decode.
REQ-009 ser  output  1  current bit presented to the CPU serial input.
REQ-010 empty  output  1  no active word and FIFO empty.
REQ-011 underflow  output  1  sticky flag: rd_bit seen while no bit was available.
REQ-012 level  output  $clog2(DEPTH)+1  words held in the FIFO, excluding the active word.

Function
REQ-013 Storage: DEPTH x 32 circular FIFO with read/write pointers that wrap modulo DEPTH; 32-bit shift register (shreg); 5-bit bit counter (bcnt); state register with two states, IDLE and ACTIVE.
REQ-014 wr_ready = (level < DEPTH), derived from registered state only; it has no combinational path from rd_bit or wr_valid.
REQ-015 A write occurs when wr_valid && wr_ready; when wr_valid is high and wr_ready is low, the word is dropped and no state changes.
REQ-016 IDLE with level > 0: load the FIFO head into shreg, clear bcnt to 0, pop, and go to ACTIVE on the same edge.
REQ-017 IDLE with level = 0: remain IDLE; a word written at edge N is loaded at edge N+1, so ser is valid after edge N+1 (2-cycle write-to-bit latency).
REQ-018 ser = shreg[31] in ACTIVE and 0 in IDLE; ser is driven directly from a register.
REQ-019 ACTIVE, rd_bit, bcnt < 31: shift shreg left by one bit with 0 fill, and increment bcnt.
REQ-020 ACTIVE, rd_bit, bcnt = 31, level > 0: load the FIFO head and pop on the same edge with bcnt reset to 0, giving a gapless bitstream with no IDLE cycle.
REQ-021 ACTIVE, rd_bit, bcnt = 31, level = 0: go to IDLE.
REQ-022 ACTIVE without rd_bit: hold shreg and bcnt.
REQ-023 rd_bit in IDLE: set underflow; no other state change; ser remains 0.
REQ-024 Simultaneous push and pop on one edge: level is unchanged and both pointers advance; this is legal at any level, including level = DEPTH on the edge when a pop frees a slot (wr_ready is still low that cycle, so no write occurs).
REQ-025 level changes by +1 on push only, -1 on pop only, 0 on both or neither; level never exceeds DEPTH and never goes below 0.
REQ-026 clr has the highest priority: pointers, level, bcnt, and shreg go to 0, state goes to IDLE, and underflow is cleared; any same-cycle write or rd_bit is ignored.
REQ-027 empty = (state == IDLE) && (level == 0), registered-equivalent.
REQ-028 rd_bit asserted on consecutive cycles consumes one bit per cycle; there is no throughput limit.

Reset
REQ-029 While rst is low: state IDLE, pointers 0, level 0, bcnt 0, shreg 0, ser 0, underflow 0, empty 1, wr_ready 1.
REQ-030 Asserting rst mid-word discards the active word and all queued words immediately, without waiting for a clock edge.
REQ-031 After rst deasserts, the first write is accepted on the first rising edge; FIFO contents need no reset.

Verification
REQ-032 Single word: write 0x80000001, wait 2 cycles, then pulse rd_bit 32 times -> ser sequence is 1, 30 zeros, 1; afterwards empty=1 and underflow=0.
REQ-033 Gapless: write 0xFFFF0000 and 0x0000FFFF, then 64 consecutive rd_bit pulses -> bits are 16x1, 32x0, 16x1 with no stall; empty=1 on the cycle after the 64th pulse.
REQ-034 Full FIFO: with rd_bit held low, hold wr_valid high for 10 cycles of distinct data (DEPTH=4) -> 5 words accepted (1 active + 4 queued), level=4, wr_ready=0, and the later words are dropped; draining 160 bits returns exactly the first 5 words in order.
REQ-035 Underflow: pulse rd_bit while empty -> underflow=1 and ser=0; pulse clr -> underflow=0, level=0, state IDLE.
REQ-036 Simultaneous events: with level=4, pulse rd_bit on the 32nd bit while wr_valid=1 -> pop occurs, write is refused (wr_ready=0), level=3, then wr_ready=1 on the next cycle.
REQ-037 Asynchronous reset: assert rst between edges mid-word (bcnt=12, level=2) -> ser=0, level=0, empty=1 before the next edge; a write after release is serialized correctly.
